// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding and strobe-width helper.
// Bus monitors import this package to decode the master's state.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog for apb_master; only built with APB_MASTER_TIMEOUT_EN.
// expired_o fires on the wait cycle that brings the count up to MAX_COUNT.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_timeout_counter #(
  parameter int unsigned MAX_COUNT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready request in, SETUP/ACCESS on the bus, held response out.
// APB_MASTER_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on the ACCESS phase.
//
//   state  | meaning
//   IDLE   | req_ready=1, waiting for a request
//   SETUP  | psel=1, penable=0, one cycle
//   ACCESS | psel=1, penable=1, waiting for pready
//   RESP   | resp_valid=1, holding data/err until resp_ready
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                                pclk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]   req_wstrb,
  input  logic                                req_write,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [DATA_WIDTH-1:0]               resp_rdata,
  output logic                                resp_err,
  output logic [ADDR_WIDTH-1:0]               paddr,
  output logic [DATA_WIDTH-1:0]               pdata,
  input  logic [DATA_WIDTH-1:0]               prdata,
  output logic                                psel,
  output logic                                penable,
  output logic                                pwrite,
  output logic [strb_width(DATA_WIDTH)-1:0]   pstb,
  input  logic                                pready,
  input  logic                                perr
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [STRB_WIDTH-1:0] pstb_q, pstb_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_counter #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (pclk),
    .reset     (reset),
    .clear_i   (state_q == ST_SETUP),
    .enable_i  ((state_q == ST_ACCESS) && !pready),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pdata_d  = pdata_q;
    pstb_d   = pstb_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pdata_d  = req_write ? req_wdata : '0;
          pstb_d   = req_write ? req_wstrb : '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completing responder wins over a watchdog expiring in the same cycle.
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = perr;
          state_d = ST_RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pdata_q  <= '0;
      pstb_q   <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      pstb_q   <= pstb_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign psel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable    = (state_q == ST_ACCESS);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign paddr      = paddr_q;
  assign pdata      = pdata_q;
  assign pstb       = pstb_q;
  assign pwrite     = pwrite_q;

endmodule
